// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - byte-wide RAM port arbiter between IF fetch and MEM load/store
// Sticky-grant arbitration with MEM priority, IO store hold-off and owner-tagged read return.
module mem_arbiter #(
  parameter int         ADDR_W = 32,
  parameter logic [1:0] IO_HI  = 2'b11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_request,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic [1:0]        mem_request,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data_i,
  input  logic              io_buffer_full,
  output logic              if_grant,
  output logic              mem_grant,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din,
  output logic [7:0]        data_o,
  output logic [1:0]        if_or_mem
);

  typedef enum logic [1:0] {
    OWN_IDLE = 2'b00,
    OWN_IF   = 2'b01,
    OWN_MEM  = 2'b10
  } owner_t;

  localparam logic [1:0] TAG_NONE = 2'b00;
  localparam logic [1:0] TAG_IF   = 2'b01;
  localparam logic [1:0] TAG_MEM  = 2'b10;

  owner_t     owner, owner_nx;
  logic [1:0] tag, tag_nx;
  logic       mem_want, mem_store;
  logic       sel_if, sel_mem, hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner <= OWN_IDLE;
      tag   <= TAG_NONE;
    end else begin
      owner <= owner_nx;
      tag   <= tag_nx;
    end
  end

  always_comb begin
    mem_want  = (mem_request == 2'b01) || (mem_request == 2'b10);
    mem_store = (mem_request == 2'b10);
    sel_if    = 1'b0;
    sel_mem   = 1'b0;
    owner_nx  = OWN_IDLE;
    tag_nx    = TAG_NONE;
    if_grant  = 1'b0;
    mem_grant = 1'b0;
    ram_a     = '0;
    ram_wr    = 1'b0;
    ram_dout  = 8'h00;

    // A current owner that keeps requesting holds the port; otherwise MEM wins.
    if (owner == OWN_IF && if_request)
      sel_if = 1'b1;
    else if (owner == OWN_MEM && mem_want)
      sel_mem = 1'b1;
    else if (mem_want)
      sel_mem = 1'b1;
    else if (if_request)
      sel_if = 1'b1;

    hold = sel_mem && mem_store && (mem_addr[17:16] == IO_HI) && io_buffer_full;

    if (sel_if) begin
      if_grant = 1'b1;
      ram_a    = if_addr;
      owner_nx = OWN_IF;
      tag_nx   = TAG_IF;
    end else if (sel_mem) begin
      owner_nx = OWN_MEM;
      if (!hold) begin
        mem_grant = 1'b1;
        ram_a     = mem_addr;
        ram_wr    = mem_store;
        ram_dout  = mem_store ? mem_data_i : 8'h00;
        tag_nx    = mem_store ? TAG_NONE : TAG_MEM;
      end
    end
  end

  assign data_o    = ram_din;
  assign if_or_mem = tag;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter against a RAM model and reference arbiter
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_request;
  logic [31:0] if_addr;
  logic [1:0]  mem_request;
  logic [31:0] mem_addr;
  logic [7:0]  mem_data_i;
  logic        io_buffer_full;
  logic        if_grant;
  logic        mem_grant;
  logic [31:0] ram_a;
  logic        ram_wr;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din;
  logic [7:0]  data_o;
  logic [1:0]  if_or_mem;

  int n_assert = 0;
  int n_fail   = 0;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .if_request(if_request), .if_addr(if_addr),
    .mem_request(mem_request), .mem_addr(mem_addr), .mem_data_i(mem_data_i),
    .io_buffer_full(io_buffer_full),
    .if_grant(if_grant), .mem_grant(mem_grant),
    .ram_a(ram_a), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din),
    .data_o(data_o), .if_or_mem(if_or_mem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] pat(logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5C;
  endfunction

  // Environment RAM: synchronous write, registered read.
  bit         ram_written [65536];
  logic [7:0] ram_mem     [65536];
  always @(posedge clk) begin
    if (ram_wr) begin
      ram_mem[ram_a[15:0]]     <= ram_dout;
      ram_written[ram_a[15:0]] <= 1'b1;
    end
    ram_din <= ram_written[ram_a[15:0]] ? ram_mem[ram_a[15:0]] : pat(ram_a[15:0]);
  end

  // Reference model state: who owns the port, what tag and byte are due next cycle.
  bit         exp_written [65536];
  logic [7:0] exp_mem     [65536];
  int         m_owner = 0;   // 0 none, 1 IF, 2 MEM
  logic [1:0] m_tag   = 2'b00;
  logic [7:0] m_byte  = 8'h00;

  function automatic logic [7:0] exp_rd(logic [31:0] a);
    return exp_written[a[15:0]] ? exp_mem[a[15:0]] : pat(a[15:0]);
  endfunction

  task automatic chk(string name, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // One clock: check combinational outputs mid-cycle, then advance the model at the edge.
  task automatic step();
    int          who;
    bit          keep, want_mem, hold;
    logic        e_ig, e_mg, e_wr;
    logic [31:0] e_a;
    logic [7:0]  e_dout;
    #4;
    want_mem = (mem_request == 2'd1) || (mem_request == 2'd2);
    keep     = (m_owner == 1 && if_request) || (m_owner == 2 && want_mem);
    who      = keep ? m_owner : (want_mem ? 2 : (if_request ? 1 : 0));
    hold     = (who == 2) && (mem_request == 2'd2) && (mem_addr[17:16] == 2'b11) && io_buffer_full;
    e_ig     = (who == 1);
    e_mg     = (who == 2) && !hold;
    e_a      = e_ig ? if_addr : (e_mg ? mem_addr : 32'h0);
    e_wr     = e_mg && (mem_request == 2'd2);
    e_dout   = e_wr ? mem_data_i : 8'h00;
    chk("if_grant", if_grant, e_ig);
    chk("mem_grant", mem_grant, e_mg);
    chk("ram_a", ram_a, e_a);
    chk("ram_wr", ram_wr, e_wr);
    chk("ram_dout", ram_dout, e_dout);
    chk("if_or_mem", if_or_mem, m_tag);
    if (m_tag != 2'b00) chk("data_o", data_o, m_byte);
    @(posedge clk);
    if (rst) begin
      m_owner = 0;
      m_tag   = 2'b00;
    end else begin
      m_owner = who;
      if (e_ig) begin
        m_tag  = 2'b01;
        m_byte = exp_rd(if_addr);
      end else if (e_mg && mem_request == 2'd1) begin
        m_tag  = 2'b10;
        m_byte = exp_rd(mem_addr);
      end else begin
        m_tag = 2'b00;
      end
      if (e_wr) begin
        exp_mem[mem_addr[15:0]]     = mem_data_i;
        exp_written[mem_addr[15:0]] = 1'b1;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    if_request     = 1'b0;
    if_addr        = 32'h0;
    mem_request    = 2'b00;
    mem_addr       = 32'h0;
    mem_data_i     = 8'h00;
    io_buffer_full = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    #2;
    chk("rst_if_or_mem", if_or_mem, 2'b00);
    chk("rst_ram_a", ram_a, 32'h0);
    chk("rst_ram_wr", ram_wr, 1'b0);
    chk("rst_ram_dout", ram_dout, 8'h00);
    chk("rst_grants", {if_grant, mem_grant}, 2'b00);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();

    // IF-only burst
    for (int i = 0; i < 4; i++) begin
      if_request = 1'b1;
      if_addr    = 32'h100 + i;
      step();
    end
    idle_inputs();
    step();

    // Simultaneous first requests from IDLE: MEM wins
    if_request  = 1'b1; if_addr  = 32'h104;
    mem_request = 2'b01; mem_addr = 32'h2000;
    #1;
    chk("t2_mem_grant", mem_grant, 1'b1);
    chk("t2_if_grant", if_grant, 1'b0);
    chk("t2_ram_a", ram_a, 32'h2000);
    step();
    mem_request = 2'b00;
    step();

    // Sticky IF while MEM waits, then hand-over with no bubble
    mem_request = 2'b01; mem_addr = 32'h2004;
    if_addr = 32'h105;
    step();
    if_addr = 32'h106;
    step();
    if_request = 1'b0;
    #1;
    chk("t3_handover", mem_grant, 1'b1);
    step();
    idle_inputs();
    step();

    // Plain store
    mem_request = 2'b10; mem_addr = 32'h1F00; mem_data_i = 8'hA5;
    step();
    idle_inputs();
    step();
    chk("t4_ram_content", ram_mem[16'h1F00], 8'hA5);
    mem_request = 2'b01; mem_addr = 32'h1F00;
    step();
    idle_inputs();
    step();

    // IO store held off while the buffer is full, IF also asking
    if_request = 1'b1; if_addr = 32'h200;
    mem_request = 2'b10; mem_addr = 32'h30000; mem_data_i = 8'h3C;
    io_buffer_full = 1'b1;
    for (int i = 0; i < 3; i++) step();
    io_buffer_full = 1'b0;
    #1;
    chk("t5_release_wr", ram_wr, 1'b1);
    step();
    idle_inputs();
    step();

    // Reset during a tagged MEM load
    mem_request = 2'b01; mem_addr = 32'h0042;
    step();
    rst = 1'b1;
    #1;
    chk("t6_tag_cleared", if_or_mem, 2'b00);
    m_owner = 0;
    m_tag   = 2'b00;
    idle_inputs();
    step();
    rst = 1'b0;
    if_request = 1'b1; if_addr = 32'h300;
    mem_request = 2'b01; mem_addr = 32'h0050;
    step();
    chk("t6_after_tag", if_or_mem, 2'b10);
    idle_inputs();
    step();

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      if_request     = ($urandom_range(0, 3) != 0);
      if_addr        = $urandom_range(0, 4095);
      mem_request    = 2'($urandom_range(0, 3));
      mem_addr       = ($urandom_range(0, 3) == 0) ? (32'h30000 | 32'($urandom_range(0, 255)))
                                                   : 32'($urandom_range(0, 4095));
      mem_data_i     = 8'($urandom);
      io_buffer_full = ($urandom_range(0, 2) == 0);
      step();
    end
    idle_inputs();
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
